elevator_call_scheduler: RTL

ELEVATOR_CALL_SCHEDULER -- requirements
Module: elevator_call_scheduler

---
 rtl/elevator_call_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler for a four-floor car.
// Latches hall and cab calls, moves one floor every MOVE_CYCLES clocks,
// opens the door for DOOR_CYCLES clocks at each served floor, and prefers
// the last travel direction when calls are pending on both sides.
// Optional feature: define ELEV_DOOR_HOLD_EN to add a door_hold input that
// freezes the door timer at its reload value while asserted.
module elevator_call_scheduler #(
   parameter int unsigned MOVE_CYCLES = 4,
   parameter int unsigned DOOR_CYCLES = 8
) (
   input  logic       clk,
   input  logic       reset,
`ifdef ELEV_DOOR_HOLD_EN
   input  logic       door_hold,
`endif
   input  logic [3:0] hall_req,
   input  logic [3:0] cab_req,
   output logic [1:0] floor,
   output logic       move_up,
   output logic       move_down,
   output logic       door_open,
   output logic [3:0] pending,
   output logic       idle
);

   typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDown, StDoor} state_e;

   localparam logic [7:0] MoveLast = 8'(MOVE_CYCLES - 1);
   localparam logic [7:0] DoorLast = 8'(DOOR_CYCLES - 1);

   state_e     state_q, state_d;
   logic [1:0] floor_q, floor_d;
   logic [3:0] pending_q, pending_d;
   logic       last_up_q, last_up_d;
   logic [7:0] cnt_q, cnt_d;

   logic [3:0] served;
   logic [3:0] req_now;
   logic [3:0] here_hot;
   logic       going_up;
   logic       step_ok;
   logic [1:0] next_floor;
   logic [3:0] next_hot;
   logic       has_above, has_below, beyond;

   // Floors strictly above f; shifting past bit 3 drops out naturally.
   function automatic logic [3:0] above_of(input logic [1:0] f);
      return 4'b1110 << f;
   endfunction

   // Floors strictly below f.
   function automatic logic [3:0] below_of(input logic [1:0] f);
      return ~(above_of(f) | (4'b0001 << f));
   endfunction

   // Decode helpers for the current and the next floor.
   always_comb begin
      req_now    = hall_req | cab_req;
      here_hot   = 4'b0001 << floor_q;
      going_up   = (state_q == StMoveUp);
      step_ok    = going_up ? (floor_q != 2'd3) : (floor_q != 2'd0);
      next_floor = going_up ? floor_q + 2'd1 : floor_q - 2'd1;
      next_hot   = 4'b0001 << next_floor;
      has_above  = |(pending_q & above_of(floor_q));
      has_below  = |(pending_q & below_of(floor_q));
      beyond     = going_up ? |(pending_q & above_of(next_floor))
                            : |(pending_q & below_of(next_floor));
   end

   // Next-state, floor stepping, timers and call clearing.
   always_comb begin
      state_d   = state_q;
      floor_d   = floor_q;
      last_up_d = last_up_q;
      cnt_d     = cnt_q;
      served    = 4'b0000;
      unique case (state_q)
         StIdle: begin
            if (|(pending_q & here_hot)) begin
               state_d = StDoor;
               served  = here_hot;
               cnt_d   = 8'd0;
            end else if (has_above && (!has_below || last_up_q)) begin
               state_d   = StMoveUp;
               last_up_d = 1'b1;
               cnt_d     = 8'd0;
            end else if (has_below) begin
               state_d   = StMoveDown;
               last_up_d = 1'b0;
               cnt_d     = 8'd0;
            end
         end
         StMoveUp, StMoveDown: begin
            if (!step_ok) begin
               // Defensive only: the car never heads off the end of the shaft.
               state_d = StIdle;
               cnt_d   = 8'd0;
            end else if (cnt_q == MoveLast) begin
               floor_d = next_floor;
               cnt_d   = 8'd0;
               if (|(pending_q & next_hot)) begin
                  state_d = StDoor;
                  served  = next_hot;
               end else if (!beyond) begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StDoor: begin
            // Calls for the open floor are absorbed and keep the door open.
            served = here_hot;
            if (|(req_now & here_hot)) begin
               cnt_d = 8'd0;
`ifdef ELEV_DOOR_HOLD_EN
            end else if (door_hold) begin
               cnt_d = 8'd0;
`endif
            end else if (cnt_q == DoorLast) begin
               state_d = StIdle;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 8'd0;
         end
      endcase
      pending_d = (pending_q | req_now) & ~served;
   end

   // State registers; reset aborts any move and drops every call.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         floor_q   <= 2'd0;
         pending_q <= 4'b0000;
         last_up_q <= 1'b1;
         cnt_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         floor_q   <= floor_d;
         pending_q <= pending_d;
         last_up_q <= last_up_d;
         cnt_q     <= cnt_d;
      end
   end

   assign floor     = floor_q;
   assign pending   = pending_q;
   assign move_up   = (state_q == StMoveUp);
   assign move_down = (state_q == StMoveDown);
   assign door_open = (state_q == StDoor);
   assign idle      = (state_q == StIdle);

endmodule
